dmem_byte_initiator: RTL
========================

// Module: dmem_byte_initiator
// PURPOSE
//  Memory-stage initiator for the Y86-64 pipeline. Accepts one 64-bit load/store request per transaction.
//  Executes it as 8 single-byte accesses, little-endian, on a byte-wide synchronous data RAM.
//  Returns the assembled 64-bit m_valM, or an out-of-range error, and holds stall high while busy.
//  Sits between the M-stage pipeline register and the byte-addressed data memory array.
// PARAMETERS
//  MEM_BYTES   1024  size of data RAM in bytes; legal word addresses are 0..MEM_BYTES-8
//  ADDR_W      10    RAM byte-address width, clog2(MEM_BYTES)
// PORTS
//  clk        in   1       clock; all state updates on rising edge
//  reset      in   1       asynchronous, active-high reset
//  req_valid  in   1       M-stage request present
//  req_write  in   1       1 = store M_valA, 0 = load
//  req_addr   in   64      byte address of word (valE)
//  req_data   in   64      store data (M_valA)
//  req_ready  out  1       high only in IDLE; request accepted when req_valid & req_ready
//  stall      out  1       high from acceptance until resp_valid cycle inclusive
//  resp_valid out  1       one-cycle pulse: transaction complete
//  resp_data  out  64      m_valM; loaded word, 0 for stores and errors; held until next resp_valid
//  resp_error out  1       dmem_error, qualified by resp_valid
//  mem_addr   out  ADDR_W  RAM byte address
//  mem_rd_en  out  1       RAM read strobe; mem_rdata valid the cycle after
//  mem_wr_en  out  1       RAM write strobe; writes mem_wdata at mem_addr on rising edge
//  mem_wdata  out  8       RAM write byte
//  mem_rdata  in   8       RAM read byte, 1-cycle latency
// BEHAVIOUR
//  Reset values:
//   - req_ready=1; stall, resp_valid, resp_error, mem_rd_en, mem_wr_en = 0
//   - resp_data, mem_addr, mem_wdata = 0; FSM = IDLE; byte counter = 0
//  FSM states:
//   - IDLE: on accept, latch addr/data/write.
//     - If req_addr > MEM_BYTES-8 (unsigned, full 64 bits; no wrap): go to DONE with error.
//     - Otherwise go to XFER, cnt=0.
//   - XFER: drive mem_addr = addr[ADDR_W-1:0]+cnt; cnt increments 0..7.
//     - Store: mem_wr_en=1, mem_wdata = data[8*cnt+7:8*cnt].
//     - Load: mem_rd_en=1; byte returned at cnt-1 captured into resp_data[8*(cnt-1)+:8].
//     - Leaving cnt=7: store goes to DONE, load goes to DRAIN.
//   - DRAIN (load only): capture byte 7, no RAM strobe, go to DONE.
//   - DONE: resp_valid=1 with resp_error; stall=1; next cycle IDLE.
//  Latency (acceptance edge = cycle 0): error resp cycle 1; store resp cycle 9; load resp cycle 10.
//  Errors:
//   - No RAM strobe is ever issued for an errored request.
//   - resp_data=0 on error and on store.
//  req_valid while not ready is ignored (pipeline is stalled, holds request).
//  req_write sampled only at acceptance; changes mid-transaction have no effect.
//  Back-to-back: new request acceptable in the cycle after DONE (IDLE).
//  Reset mid-transaction:
//   - Immediately drops all strobes and returns to IDLE.
//   - Bytes already written remain in RAM; no resp_valid is produced.
//  mem_rd_en and mem_wr_en are never high in the same cycle.
// STRUCTURE
//  Shared package y86_mem_pkg:
//   - MEM_BYTES and WORD_BYTES=8 constants
//   - FSM state encoding IDLE/XFER/DRAIN/DONE
//   - little-endian byte-lane helper function
//  One sub-module: word_byte_lane, an 8-lane byte mux (store) and byte-enable capture register (load), indexed by counter.
//  FSM and counter live in this module.
// TESTING
//  1. Store 0x1122334455667788 @ 16:
//     -> RAM[16..23]=88,77,66,55,44,33,22,11; resp_valid cycle 9, error 0, resp_data 0.
//  2. Load @ 16 after test 1:
//     -> resp_data=0x1122334455667788 on cycle 10; stall high cycles 0-10.
//  3. Load @ 1017:
//     -> resp_valid+error cycle 1, resp_data 0, no mem_rd_en. Load @ 1016 -> succeeds, no error.
//  4. Store @ 0xFFFF_FFFF_FFFF_FFFC:
//     -> error, no mem_wr_en, RAM[0..3] unchanged.
//  5. Store @ 40 (data 0xAAAA...), reset asserted in cycle 4:
//     -> outputs at reset values, RAM[40..42]=AA, RAM[43..47] unchanged, no resp_valid.
//  6. Back-to-back store @ 8 then load @ 8 with req_valid held high:
//     -> second accepted cycle 10, load returns stored word.

Source files
------------

// File: rtl/y86_mem_pkg.sv
// Shared constants, FSM encoding and byte-lane helper for the Y86-64 data-memory initiator.
package y86_mem_pkg;

  localparam int unsigned MEM_BYTES  = 1024;
  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned ADDR_W     = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Little-endian: lane 0 is the least significant byte of the word.
  function automatic logic [7:0] byte_lane(input logic [63:0] word, input logic [2:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/word_byte_lane.sv
// Byte-lane datapath: selects the store byte for a lane and assembles load bytes into a word.
module word_byte_lane
  import y86_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_cap_en,
  input  logic [2:0]  i_cap_idx,
  input  logic [7:0]  i_rbyte,
  input  logic [63:0] i_wdata,
  input  logic [2:0]  i_wr_idx,
  output logic [7:0]  o_wbyte,
  output logic [63:0] o_word_next
);

  logic [63:0] r_word;
  logic [63:0] w_word_next;

  always_comb begin
    w_word_next = r_word;
    if (i_clear) begin
      w_word_next = '0;
    end else begin
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
        if (i_cap_en && (i_cap_idx == 3'(b))) begin
          w_word_next[8*b +: 8] = i_rbyte;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word <= '0;
    end else begin
      r_word <= w_word_next;
    end
  end

  assign o_wbyte     = byte_lane(i_wdata, i_wr_idx);
  // Exposes the post-capture word so the final byte can be published on the same edge.
  assign o_word_next = w_word_next;

endmodule

// File: rtl/dmem_byte_initiator.sv
// Y86-64 memory-stage initiator: runs a 64-bit load/store as eight byte accesses on a byte RAM.
module dmem_byte_initiator #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [63:0]       req_addr,
  input  logic [63:0]       req_data,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [63:0]       resp_data,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  import y86_mem_pkg::*;

  state_e              r_state;
  state_e              w_next_state;
  logic [2:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [63:0]         r_data;
  logic                r_write;
  logic                r_err;
  logic [63:0]         r_resp_data;

  logic                w_accept;
  logic                w_oob;
  logic                w_last;
  logic                w_cap_en;
  logic [7:0]          w_wbyte;
  logic [63:0]         w_word_next;

  assign w_accept = req_valid && (r_state == IDLE);
  // Full 64-bit compare so addresses near 2^64 cannot wrap into range.
  assign w_oob    = req_addr > 64'(MEM_BYTES - WORD_BYTES);
  assign w_last   = (r_cnt == 3'd7);
  // Read data lags its strobe by one cycle, so lane cnt-1 is captured; DRAIN sees cnt wrapped to 0.
  assign w_cap_en = ((r_state == XFER) && !r_write && (r_cnt != 3'd0)) || (r_state == DRAIN);

  word_byte_lane u_lane (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_accept),
    .i_cap_en    (w_cap_en),
    .i_cap_idx   (r_cnt - 3'd1),
    .i_rbyte     (mem_rdata),
    .i_wdata     (r_data),
    .i_wr_idx    (r_cnt),
    .o_wbyte     (w_wbyte),
    .o_word_next (w_word_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  if (w_accept) w_next_state = w_oob ? DONE : XFER;
      XFER:  if (w_last)   w_next_state = r_write ? DONE : DRAIN;
      DRAIN: w_next_state = DONE;
      DONE:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_resp_data <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_addr  <= req_addr[ADDR_W-1:0];
        r_data  <= req_data;
        r_write <= req_write;
        r_err   <= w_oob;
        if (w_oob) r_resp_data <= '0;
      end else if (r_state == XFER) begin
        r_cnt <= r_cnt + 3'd1;
        if (w_last && r_write) r_resp_data <= '0;
      end else if (r_state == DRAIN) begin
        r_resp_data <= w_word_next;
      end
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    stall      = 1'b0;
    resp_valid = 1'b0;
    resp_error = 1'b0;
    mem_addr   = '0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_wdata  = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
      end
      XFER: begin
        stall    = 1'b1;
        mem_addr = r_addr + ADDR_W'(r_cnt);
        if (r_write) begin
          mem_wr_en = 1'b1;
          mem_wdata = w_wbyte;
        end else begin
          mem_rd_en = 1'b1;
        end
      end
      DRAIN: stall = 1'b1;
      DONE: begin
        stall      = 1'b1;
        resp_valid = 1'b1;
        resp_error = r_err;
      end
      default: ;
    endcase
  end

  assign resp_data = r_resp_data;

endmodule
